fsm_serial_tx: RTL



---
 rtl/fsm_serial_tx_pkg.sv | 19 +
 rtl/fsm_serial_tx_comb_logic.sv | 98 +++++++++
 rtl/fsm_serial_tx.sv | 74 +++++++
 3 files changed

// File: rtl/fsm_serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
// State encodings stay plain constants so legacy code comparing raw
// state values keeps working. PARITY is only reachable when the build
// defines FSM_SERIAL_TX_PARITY_EN.
package fsm_serial_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_STOP   = 3'd3;
    localparam state_t S_PARITY = 3'd4;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/fsm_serial_tx_comb_logic.sv
// Next-state, next-datapath and Moore output decode for fsm_serial_tx.
// Purely combinational; the registers live in the top level.
// Optional feature macro: FSM_SERIAL_TX_PARITY_EN (adds the parity bit).
module fsm_serial_tx_comb_logic
    import fsm_serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  state_t           state,
    input  logic [WIDTH-1:0] shreg,
    input  logic [CW-1:0]    cnt,
`ifdef FSM_SERIAL_TX_PARITY_EN
    input  logic             par,
    output logic             par_nxt,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output state_t           state_nxt,
    output logic [WIDTH-1:0] shreg_nxt,
    output logic [CW-1:0]    cnt_nxt,
    output logic             tx,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Transition and output decode; unknown encodings fall back to IDLE with the line idle.
    always_comb begin
        state_nxt = S_IDLE;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
`ifdef FSM_SERIAL_TX_PARITY_EN
        par_nxt   = par;
`endif
        tx        = TX_IDLE_LEVEL;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready     = 1'b1;
                state_nxt = S_IDLE;
                if (start) begin
                    state_nxt = S_START;
                    shreg_nxt = data;
                    cnt_nxt   = '0;
`ifdef FSM_SERIAL_TX_PARITY_EN
                    par_nxt   = 1'b0;
`endif
                end
            end
            S_START: begin
                tx        = START_LEVEL;
                busy      = 1'b1;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                tx        = shreg[0];
                busy      = 1'b1;
                shreg_nxt = shreg >> 1;
`ifdef FSM_SERIAL_TX_PARITY_EN
                par_nxt   = par ^ shreg[0];
`endif
                if (cnt == LAST) begin
`ifdef FSM_SERIAL_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end else begin
                    // counter holds on the last bit so it never wraps on its own
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = S_DATA;
                end
            end
`ifdef FSM_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                tx        = par;
                busy      = 1'b1;
                state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                tx        = STOP_LEVEL;
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit. Words are accepted via start/ready.
// Optional feature macro: FSM_SERIAL_TX_PARITY_EN.
module fsm_serial_tx
    import fsm_serial_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
`ifdef FSM_SERIAL_TX_PARITY_EN
    logic             par, par_nxt;
`endif

    fsm_serial_tx_comb_logic #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_comb (
        .state     (state),
        .shreg     (shreg),
        .cnt       (cnt),
`ifdef FSM_SERIAL_TX_PARITY_EN
        .par       (par),
        .par_nxt   (par_nxt),
`endif
        .start     (start),
        .data      (data),
        .state_nxt (state_nxt),
        .shreg_nxt (shreg_nxt),
        .cnt_nxt   (cnt_nxt),
        .tx        (tx),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    // State, shift register and bit counter; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef FSM_SERIAL_TX_PARITY_EN
    // Running even parity of the bits already shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= 1'b0;
        end else begin
            par <= par_nxt;
        end
    end
`endif

endmodule
